// File: rtl/tt_store_port_arb.sv
// Two-requester store port arbiter: per-requester credit-managed FIFOs feeding one
// downstream port with packet locking. Define TT_STORE_ARB_FIXED_PRIO_EN for fixed priority to requester 0.
module tt_store_port_arb #(
   parameter int DATA_W      = 512,
   parameter int FIFO_DEPTH  = 4,
   parameter int MEM_CREDITS = 4
) (
   input  logic                i_clk,
   input  logic                i_reset_n,
   input  logic [1:0]          i_req_valid,
   input  logic [2*DATA_W-1:0] i_req_data,
   input  logic [1:0]          i_req_last,
   output logic [1:0]          o_req_credit,
   output logic                o_mem_valid,
   output logic [DATA_W-1:0]   o_mem_data,
   output logic                o_mem_last,
   output logic                o_mem_src,
   input  logic                i_mem_credit,
   output logic                o_busy,
   output logic                o_err
);

   // state | meaning
   // IDLE  | no packet owns the port; pick next requester
   // SEND0 | port locked to requester 0 until its last beat pops
   // SEND1 | port locked to requester 1 until its last beat pops

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int CRD_W = $clog2(MEM_CREDITS + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SEND0 = 2'd1,
      SEND1 = 2'd2
   } state_t;

   state_t                 state;
   logic [CRD_W-1:0]       mem_crd;
   logic [1:0]             fifo_ne;
   logic [1:0]             fifo_full;
   logic [1:0]             pop;
   logic [1:0]             push_ok;
   logic [1:0]             push_drop;
   logic [1:0][DATA_W:0]   head;
   logic                   both_pick;
   logic                   owner_ne;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Per-requester FIFOs of {last, data}
   for (genvar g = 0; g < 2; g++) begin : g_fifo
      logic [DATA_W:0]  mem [FIFO_DEPTH];
      logic [PTR_W-1:0] rd_ptr;
      logic [PTR_W-1:0] wr_ptr;
      logic [CNT_W-1:0] cnt;

      always_ff @(posedge i_clk) begin
         if (push_ok[g]) begin
            mem[wr_ptr] <= {i_req_last[g], i_req_data[g*DATA_W +: DATA_W]};
         end
      end

      always_ff @(posedge i_clk) begin
         if (!i_reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
         end else begin
            if (push_ok[g]) wr_ptr <= ptr_inc(wr_ptr);
            if (pop[g])     rd_ptr <= ptr_inc(rd_ptr);
            case ({push_ok[g], pop[g]})
               2'b10:   cnt <= cnt + CNT_W'(1);
               2'b01:   cnt <= cnt - CNT_W'(1);
               default: cnt <= cnt;
            endcase
         end
      end

      assign head[g]      = mem[rd_ptr];
      assign fifo_ne[g]   = (cnt != '0);
      assign fifo_full[g] = (cnt == CNT_W'(FIFO_DEPTH));
      // a full FIFO still takes a beat when its head leaves in the same cycle
      assign push_ok[g]   = i_req_valid[g] & (~fifo_full[g] | pop[g]);
      assign push_drop[g] = i_req_valid[g] & fifo_full[g] & ~pop[g];
   end

   assign o_mem_src = (state == SEND1);
   assign owner_ne  = (state == SEND0) ? fifo_ne[0] :
                      (state == SEND1) ? fifo_ne[1] : 1'b0;

   // outputs are forced low while reset is held so nothing pops or returns credit
   assign o_mem_valid  = i_reset_n & owner_ne & (mem_crd != '0);
   assign pop          = {o_mem_valid & o_mem_src, o_mem_valid & ~o_mem_src};
   assign o_req_credit = pop;
   assign {o_mem_last, o_mem_data} = head[o_mem_src];
   assign o_busy       = i_reset_n & ((|fifo_ne) | (state != IDLE));

`ifdef TT_STORE_ARB_FIXED_PRIO_EN
   assign both_pick = 1'b0;
`else
   logic rr_ptr;

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         rr_ptr <= 1'b0;
      end else if (o_mem_valid && o_mem_last) begin
         rr_ptr <= ~o_mem_src;
      end
   end

   assign both_pick = rr_ptr;
`endif

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         state   <= IDLE;
         mem_crd <= CRD_W'(MEM_CREDITS);
         o_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               case (fifo_ne)
                  2'b01:   state <= SEND0;
                  2'b10:   state <= SEND1;
                  2'b11:   state <= both_pick ? SEND1 : SEND0;
                  default: state <= IDLE;
               endcase
            end
            SEND0, SEND1: begin
               if (o_mem_valid && o_mem_last) state <= IDLE;
            end
            default: state <= IDLE;
         endcase

         if (i_mem_credit && !o_mem_valid) begin
            if (mem_crd == CRD_W'(MEM_CREDITS)) o_err <= 1'b1;
            else                                mem_crd <= mem_crd + CRD_W'(1);
         end else if (!i_mem_credit && o_mem_valid) begin
            mem_crd <= mem_crd - CRD_W'(1);
         end

         if (|push_drop) o_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_tt_store_port_arb.sv
// Directed bench for tt_store_port_arb: table-driven arbitration vectors plus
// hand sequences for credit starvation, overflow, credit saturation and mid-packet reset.
module tb_tt_store_port_arb;

   localparam int DW = 32;
   localparam logic [31:0] A = 32'hA000_0000;
   localparam logic [31:0] B = 32'hB000_0000;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [1:0]      req_valid;
   logic [2*DW-1:0] req_data;
   logic [1:0]      req_last;
   logic [1:0]      req_credit;
   logic            mem_valid;
   logic [DW-1:0]   mem_data;
   logic            mem_last;
   logic            mem_src;
   logic            mem_credit;
   logic            busy;
   logic            err;

   int total = 0;
   int bad   = 0;

   logic            s_valid, s_last, s_src, s_busy, s_err;
   logic [DW-1:0]   s_data;
   logic [1:0]      s_credit;
   logic [2:0]      s_crd;

   tt_store_port_arb #(.DATA_W(DW), .FIFO_DEPTH(4), .MEM_CREDITS(4)) dut (
      .i_clk        (clk),
      .i_reset_n    (rst_n),
      .i_req_valid  (req_valid),
      .i_req_data   (req_data),
      .i_req_last   (req_last),
      .o_req_credit (req_credit),
      .o_mem_valid  (mem_valid),
      .o_mem_data   (mem_data),
      .o_mem_last   (mem_last),
      .o_mem_src    (mem_src),
      .i_mem_credit (mem_credit),
      .o_busy       (busy),
      .o_err        (err)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   typedef struct {
      logic [1:0]  rv;
      logic [1:0]  rl;
      logic [31:0] d0;
      logic [31:0] d1;
      logic        mc;
      logic        ev;
      logic        es;
      logic        el;
      logic [31:0] ed;
      logic [1:0]  ec;
      logic        eb;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // drive one cycle, snapshot outputs at the falling edge, return just after the next rising edge
   task automatic cyc(input logic [1:0] rv, input logic [1:0] rl, input logic [31:0] d0,
                      input logic [31:0] d1, input logic mc);
      req_valid  = rv;
      req_last   = rl;
      req_data   = {d1, d0};
      mem_credit = mc;
      @(negedge clk);
      s_valid  = mem_valid;
      s_last   = mem_last;
      s_src    = mem_src;
      s_data   = mem_data;
      s_credit = req_credit;
      s_busy   = busy;
      s_err    = err;
      s_crd    = dut.mem_crd;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input logic mc);
      cyc(2'b00, 2'b00, 32'h0, 32'h0, mc);
   endtask

   task automatic reset_dut();
      rst_n = 1'b0;
      idle(1'b0);
      idle(1'b0);
      chk("rst_valid", s_valid, 0);
      chk("rst_credit", s_credit, 0);
      chk("rst_busy", s_busy, 0);
      rst_n = 1'b1;
   endtask

   task automatic row(input logic [1:0] rv, input logic [1:0] rl, input logic [31:0] d0,
                      input logic [31:0] d1, input logic mc, input logic ev, input logic es,
                      input logic el, input logic [31:0] ed, input logic [1:0] ec, input logic eb);
      vec_t v;
      v.rv = rv; v.rl = rl; v.d0 = d0; v.d1 = d1; v.mc = mc;
      v.ev = ev; v.es = es; v.el = el; v.ed = ed; v.ec = ec; v.eb = eb;
      tbl.push_back(v);
   endtask

   // both requesters push a 2-beat packet in the same two cycles; first/second is the expected grant order
   task automatic contention(input logic first);
      logic second;
      second = ~first;
      row(2'b11, 2'b00, A + 0, B + 0, 1'b0, 0, 0, 0, 0, 2'b00, 0);
      row(2'b11, 2'b11, A + 1, B + 1, 1'b0, 0, 0, 0, 0, 2'b00, 1);
      row(2'b00, 2'b00, 0, 0, 1'b1, 1, first, 0, (first ? B : A) + 0, first ? 2'b10 : 2'b01, 1);
      row(2'b00, 2'b00, 0, 0, 1'b1, 1, first, 1, (first ? B : A) + 1, first ? 2'b10 : 2'b01, 1);
      row(2'b00, 2'b00, 0, 0, 1'b0, 0, 0, 0, 0, 2'b00, 1);
      row(2'b00, 2'b00, 0, 0, 1'b1, 1, second, 0, (second ? B : A) + 0, second ? 2'b10 : 2'b01, 1);
      row(2'b00, 2'b00, 0, 0, 1'b1, 1, second, 1, (second ? B : A) + 1, second ? 2'b10 : 2'b01, 1);
      row(2'b00, 2'b00, 0, 0, 1'b0, 0, 0, 0, 0, 2'b00, 0);
   endtask

   initial begin
      logic rr_second;
      int   nv;
      int   nc;
      int   k;

`ifdef TT_STORE_ARB_FIXED_PRIO_EN
      rr_second = 1'b0;
`else
      rr_second = 1'b1;
`endif

      // contention from reset, a lone req0 packet (moves pointer to req1), contention again
      contention(1'b0);
      row(2'b01, 2'b00, A + 0, 0, 1'b0, 0, 0, 0, 0, 2'b00, 0);
      row(2'b01, 2'b00, A + 1, 0, 1'b0, 0, 0, 0, 0, 2'b00, 1);
      row(2'b01, 2'b01, A + 2, 0, 1'b1, 1, 0, 0, A + 0, 2'b01, 1);
      row(2'b00, 2'b00, 0, 0, 1'b1, 1, 0, 0, A + 1, 2'b01, 1);
      row(2'b00, 2'b00, 0, 0, 1'b1, 1, 0, 1, A + 2, 2'b01, 1);
      row(2'b00, 2'b00, 0, 0, 1'b0, 0, 0, 0, 0, 2'b00, 0);
      contention(rr_second);

      req_valid = 2'b00; req_last = 2'b00; req_data = '0; mem_credit = 1'b0;
      @(posedge clk);
      #1;
      reset_dut();
      idle(1'b0);
      chk("reset_err", s_err, 0);
      chk("reset_crd", s_crd, 4);
      chk("reset_busy", s_busy, 0);

      foreach (tbl[i]) begin
         cyc(tbl[i].rv, tbl[i].rl, tbl[i].d0, tbl[i].d1, tbl[i].mc);
         chk($sformatf("vec%0d_valid", i), s_valid, tbl[i].ev);
         chk($sformatf("vec%0d_credit", i), s_credit, tbl[i].ec);
         chk($sformatf("vec%0d_busy", i), s_busy, tbl[i].eb);
         if (tbl[i].ev) begin
            chk($sformatf("vec%0d_src", i), s_src, tbl[i].es);
            chk($sformatf("vec%0d_last", i), s_last, tbl[i].el);
            chk($sformatf("vec%0d_data", i), s_data, tbl[i].ed);
         end
      end
      chk("tbl_crd", s_crd, 4);
      chk("tbl_err", s_err, 0);

      // credit starvation: 6-beat req0 packet, no credit returns
      nv = 0; nc = 0; k = 0;
      for (int i = 0; i < 10; i++) begin
         if (i < 6) cyc(2'b01, {1'b0, i == 5}, A + i, 0, 1'b0);
         else       idle(1'b0);
         nv = nv + int'(s_valid);
         nc = nc + int'(s_credit[0]);
         if (s_valid) begin
            chk("starve_data", s_data, A + k);
            k++;
         end
      end
      chk("starve_beats", nv, 4);
      chk("starve_credits", nc, 4);
      chk("starve_crd", s_crd, 0);
      chk("starve_stall", s_valid, 0);
      chk("starve_busy", s_busy, 1);

      // overflow on req1 while req0 holds the lock stalled
      nv = 0;
      for (int i = 0; i < 5; i++) begin
         cyc(2'b10, {i == 3, 1'b0}, 0, B + i, 1'b0);
         nv = nv + int'(s_valid);
         if (i == 4) chk("ovf_err_before", s_err, 0);
      end
      idle(1'b0);
      chk("ovf_err", s_err, 1);
      chk("ovf_no_send", nv, 0);

      // two credit returns release the last two req0 beats
      idle(1'b1);
      chk("resume_c0_valid", s_valid, 0);
      idle(1'b1);
      chk("resume_c1_valid", s_valid, 1);
      chk("resume_c1_data", s_data, A + 4);
      chk("resume_c1_last", s_last, 0);
      idle(1'b0);
      chk("resume_c2_valid", s_valid, 1);
      chk("resume_c2_data", s_data, A + 5);
      chk("resume_c2_last", s_last, 1);
      chk("resume_c2_credit", s_credit, 2'b01);
      idle(1'b0);
      chk("resume_c3_valid", s_valid, 0);
      chk("resume_c3_crd", s_crd, 0);

      reset_dut();
      idle(1'b0);
      chk("rst2_err", s_err, 0);
      chk("rst2_crd", s_crd, 4);

      // simultaneous return and send at counter 2, then spurious return at full
      for (int i = 0; i < 4; i++) cyc(2'b01, {1'b0, i == 3}, A + i, 0, 1'b0);
      chk("sat_crd3", s_crd, 3);
      idle(1'b1);
      chk("sat_pre_crd", s_crd, 2);
      chk("sat_pre_valid", s_valid, 1);
      idle(1'b0);
      chk("sat_hold_crd", s_crd, 2);
      chk("sat_hold_last", s_last, 1);
      idle(1'b1);
      idle(1'b1);
      idle(1'b1);
      idle(1'b1);
      chk("sat_full_crd", s_crd, 4);
      chk("sat_err_before", s_err, 0);
      idle(1'b0);
      chk("sat_crd_stays", s_crd, 4);
      chk("sat_err", s_err, 1);

      reset_dut();
      idle(1'b0);
      chk("rst3_err", s_err, 0);

      // reset after 2 of 4 beats
      nv = 0;
      for (int i = 0; i < 4; i++) begin
         cyc(2'b01, {1'b0, i == 3}, A + i, 0, 1'b0);
         nv = nv + int'(s_valid);
      end
      chk("midrst_sent", nv, 2);
      rst_n = 1'b0;
      idle(1'b0);
      chk("midrst_in_valid", s_valid, 0);
      chk("midrst_in_credit", s_credit, 0);
      rst_n = 1'b1;
      idle(1'b0);
      chk("midrst_valid", s_valid, 0);
      chk("midrst_busy", s_busy, 0);
      chk("midrst_crd", s_crd, 4);
      chk("midrst_credit", s_credit, 0);
      nv = 0; nc = 0;
      for (int i = 0; i < 4; i++) begin
         idle(1'b0);
         nv = nv + int'(s_valid);
         nc = nc + int'(|s_credit);
      end
      chk("midrst_quiet_valid", nv, 0);
      chk("midrst_quiet_credit", nc, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
